// File: rtl/tx10_bcd_pkg.sv
// Shared types and default sizing for the signed tenths-of-a-degree to BCD converter.
package tx10_bcd_pkg;

  localparam int W_DEF     = 18;
  localparam int NDIG_DEF  = 6;
  localparam int CNT_W_DEF = $clog2(W_DEF + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/tx10_bcd_adj3.sv
// One double-dabble digit correction: digits of 5 or more get +3 before the shift.
module bcd_adj3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/tx10_bcd.sv
// Signed binary to sign + BCD converter, one magnitude bit per clock, start/busy/done handshake.
module tx10_bcd
  import tx10_bcd_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NDIG = NDIG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      tx10,
  output logic              busy,
  output logic              done,
  output logic              sign,
  output logic [4*NDIG-1:0] bcd
);

  localparam int CW = cnt_width(W);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        mag_q, mag_d;
  logic [4*NDIG-1:0]   scr_q, scr_d;
  logic                wsign_q, wsign_d;
  logic                sign_q, done_q;
  logic [4*NDIG-1:0]   bcd_q;
  logic [4*NDIG-1:0]   adj_w;
  logic [W-1:0]        abs_w;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
    bcd_adj3 u_adj (
      .d_i (scr_q[4*gi +: 4]),
      .d_o (adj_w[4*gi +: 4])
    );
  end

  // Two's-complement negate; the most negative input maps onto 2^(W-1) unsigned.
  assign abs_w = tx10[W-1] ? (~tx10 + W'(1)) : tx10;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(W - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    wsign_d = wsign_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          wsign_d = tx10[W-1];
          mag_d   = abs_w;
          scr_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // The top digit never reaches 5, so its corrected MSB is always zero and drops out.
        scr_d = {adj_w[4*NDIG-2:0], mag_q[W-1]};
        mag_d = {mag_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mag_q   <= '0;
      scr_q   <= '0;
      wsign_q <= 1'b0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      wsign_q <= wsign_d;
      done_q  <= (state_q == DONE);
      if (state_q == DONE) begin
        sign_q <= wsign_q;
        bcd_q  <= scr_q;
      end
    end
  end

  assign done = done_q;
  assign sign = sign_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_tx10_bcd.sv
// Bench for tx10_bcd: arithmetic reference model checked every cycle plus directed literal cases.
module tb_tx10_bcd;
  import tx10_bcd_pkg::*;

  localparam int W  = 18;
  localparam int ND = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [W-1:0]    tx10 = '0;
  logic            busy, done, sign;
  logic [4*ND-1:0] bcd;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  tx10_bcd #(.W(W), .NDIG(ND)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .tx10  (tx10),
    .busy  (busy),
    .done  (done),
    .sign  (sign),
    .bcd   (bcd)
  );

  // Decimal digits of |value| by plain division.
  function automatic logic [4*ND-1:0] ref_bcd(input logic [W-1:0] v);
    int sv;
    int m;
    logic [4*ND-1:0] r;
    sv = int'($signed(v));
    m  = (sv < 0) ? -sv : sv;
    r  = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a conversion takes W+1 edges after the accept, results then hold.
  bit              m_busy = 0, m_done = 0, m_sign = 0, p_sign = 0;
  int              m_cnt = 0;
  logic [4*ND-1:0] m_bcd = '0, p_bcd = '0;
  logic [W-1:0]    p_val = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_sign = 0; m_bcd = '0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == W + 1) begin
          m_busy = 0; m_done = 1; m_sign = p_sign; m_bcd = p_bcd;
          $display("conv tx10=%0d -> sign=%0b bcd=%06h", $signed(p_val), m_sign, m_bcd);
        end
      end else if (start) begin
        m_busy = 1; m_cnt = 0;
        p_val  = tx10;
        p_sign = ($signed(tx10) < 0);
        p_bcd  = ref_bcd(tx10);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("sign", {31'd0, sign}, {31'd0, m_sign});
      chk("bcd",  {8'd0, bcd},   {8'd0, m_bcd});
    end
  end

  task automatic conv(input logic [W-1:0] v, input logic es, input logic [23:0] eb, input string nm);
    int k;
    @(negedge clk);
    tx10  = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, k - 1, 19);
    chk({nm, "_sign"}, {31'd0, sign}, {31'd0, es});
    chk({nm, "_bcd"}, {8'd0, bcd}, {8'd0, eb});
  endtask

  initial begin
    int nb, nd, d1, d2;
    logic [23:0] b1, b2;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sign", {31'd0, sign}, 32'd0);
    chk("rst_bcd",  {8'd0, bcd}, 32'd0);
    rst = 1'b0;

    conv(18'd235,   1'b0, 24'h000235, "pos235");
    conv(18'h3FF83, 1'b1, 24'h000125, "neg125");
    conv(18'd0,     1'b0, 24'h000000, "zero");
    conv(18'h1FFFF, 1'b0, 24'h131071, "maxpos");
    conv(18'h20000, 1'b1, 24'h131072, "maxneg");

    // Extra start pulse mid-conversion must be dropped.
    @(negedge clk);
    tx10 = 18'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0; nd = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) nb++;
      if (done) nd++;
      if (i == 5) begin tx10 = 18'd999; start = 1'b1; end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
    chk("ign_busy_cycles", nb, 19);
    chk("ign_done_count", nd, 1);
    chk("ign_bcd", {8'd0, bcd}, 32'h000011);

    // Reset ten cycles into a conversion aborts it.
    @(negedge clk);
    tx10 = 18'd555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sign", {31'd0, sign}, 32'd0);
    chk("abort_bcd",  {8'd0, bcd}, 32'd0);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    conv(18'd3020, 1'b0, 24'h003020, "after_abort");

    // start held high: back-to-back conversions 20 cycles apart.
    @(negedge clk);
    tx10 = 18'd100; start = 1'b1;
    @(negedge clk);
    tx10 = 18'd200;
    d1 = 0; d2 = 0; b1 = '0; b2 = '0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        if (d1 == 0) begin d1 = k; b1 = bcd; end
        else if (d2 == 0) begin d2 = k; b2 = bcd; end
      end
      if (d1 != 0 && k == d1 + 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_first_seen", {31'd0, (d1 != 0)}, 32'd1);
    chk("b2b_gap", d2 - d1, 20);
    chk("b2b_bcd1", {8'd0, b1}, 32'h000100);
    chk("b2b_bcd2", {8'd0, b2}, 32'h000200);

    // Randomized traffic, judged by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0:       tx10 = 18'h1FFFF;
        1:       tx10 = 18'h20000;
        2:       tx10 = 18'd0;
        3:       tx10 = 18'h3FFFF;
        default: tx10 = W'($urandom);
      endcase
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (25) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
